unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-port synchronous RAM between the CPU's instruction-fetch port and its load/store port, so the core can run from a unified memory instead of separate instruction ROM and data RAM. A small FSM grants one requester per access and sequences the RAM enable, write-enable and byte-select lines. It returns read data with a one-cycle valid pulse and raises a pipeline stall while any request is still outstanding.

## Interface
- ADDR_W, 32, byte address width on both requester ports and on the RAM port
- DATA_W, 32, data width; byte-select width is DATA_W/8
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- IF_REQ  in  1  fetch request, held until IF_VALID
- IF_ADDR  in  ADDR_W  fetch byte address, stable while IF_REQ is high
- IF_RDATA  out  DATA_W  fetched word, meaningful only while IF_VALID is high
- IF_VALID  out  1  one-cycle completion pulse for the fetch
- MEM_REQ  in  1  load/store request, held until MEM_VALID
- MEM_WEN  in  1  1 = store, 0 = load
- MEM_ADDR  in  ADDR_W  load/store byte address
- MEM_BYTE_SEL  in  DATA_W/8  byte lanes
- MEM_SDATA  in  DATA_W  store data
- MEM_LDATA  out  DATA_W  load data, meaningful only while MEM_VALID is high
- MEM_VALID  out  1  one-cycle completion pulse, for loads and stores
- STALL  out  1  pipeline stall
- RAM_CEN, RAM_WEN  out  1  registered RAM enable and write enable
- RAM_ADDR  out  ADDR_W  registered RAM address
- RAM_BYTE_SEL  out  DATA_W/8  registered byte lanes
- RAM_SDATA  out  DATA_W  registered write data
- RAM_LDATA  in  DATA_W  RAM read data, valid one cycle after RAM_CEN

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - No request pending: stay in IDLE.
  - Request pending: select a winner, latch its command into the RAM_* registers, and go to ACCESS.
- ACCESS
  - RAM_CEN=1 for exactly this cycle.
  - A store writes at the end of this cycle.
  - Go to RESP unconditionally.
- RESP
  - RAM_CEN=0.
  - Capture RAM_LDATA into the winner's RDATA/LDATA register and pulse the winner's VALID.
  - The winner is excluded from arbitration this cycle, because its REQ still belongs to the request being completed.
  - If the other requester's REQ is high, grant it and go to ACCESS; otherwise go to IDLE.
- Fetch command: RAM_WEN=0 and RAM_BYTE_SEL all ones.
- Load/store command: MEM_* fields are passed through unchanged. No alignment checking is done; the RAM handles byte lanes.
- Default arbitration, when both requests arrive in IDLE: MEM wins, since it belongs to the older instruction.
- STALL = (IF_REQ & ~IF_VALID) | (MEM_REQ & ~MEM_VALID). It is combinational.
- RDATA/LDATA registers keep their last value between VALID pulses.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE.
- Asserting RST_N low forces RAM_CEN=0 and RAM_WEN=0 immediately, with no completion pulse.
  - A store whose ACCESS cycle was cut by the reset is not guaranteed to have written.
- Single request in IDLE:
  - REQ high in cycle t, ACCESS in t+1, VALID and data in t+2.
  - Latency is 2 cycles for both loads and stores.
- Sustained throughput is one access per 2 cycles.
- Both ports busy: the accesses alternate as ACCESS, RESP, ACCESS, RESP.
  - The loser of the first arbitration is granted from RESP, so its VALID arrives at t+4.
- Requester rule: REQ may stay high in the VALID cycle; the arbiter treats that as the same request.
  - A new request from the same port is recognized from the cycle after VALID.
- Changing ADDR or data while REQ is high and VALID has not arrived is illegal; the arbiter uses the values latched at grant.

## Configuration
- ARB_RR_EN defined:
  - A last-grant flag, reset to IF, makes simultaneous requests in IDLE go to the port not granted last.
  - After reset, MEM wins the first tie.
- ARB_RR_EN undefined:
  - Fixed priority, MEM over IF.
  - The RESP-cycle exclusion still prevents either port from starving the other.

## Structure
- Shared package mips_mem_pkg holds:
  - arb_state_t enum {IDLE, ACCESS, RESP}
  - grant_t enum {GNT_IF, GNT_MEM}
  - constant BYTE_SEL_ALL
- One sub-module, arb_pick: combinational winner selection from the two REQs, the exclusion mask and (with ARB_RR_EN) the last-grant flag.

## Test plan
- Lone fetch: IF_REQ=1 with IF_ADDR=0x0000_0010, memory word 0x2408_0005 -> IF_VALID at t+2 with IF_RDATA=0x2408_0005, STALL high at t..t+1.
- Store then load:
  - MEM_WEN=1, ADDR=0x40, BYTE_SEL=4'b0011, SDATA=0xAABB_CCDD over a word of 0x1122_3344 -> MEM_VALID at t+2.
  - Following load of 0x40 -> MEM_LDATA=0x1122_CCDD.
- Simultaneous IF and MEM requests from IDLE -> MEM_VALID at t+2, IF_VALID at t+4; RAM_CEN high only at t+1 and t+3.
- Both requests held continuously for 8 cycles -> grants alternate with no back-to-back wins for either port; with ARB_RR_EN, the tie winner flips on each return to IDLE.
- RST_N pulled low during ACCESS of a store -> RAM_CEN/RAM_WEN 0 in the same cycle, all outputs 0, FSM in IDLE, no VALID after release.
- REQ held high through its VALID cycle with the other port idle -> FSM goes to IDLE and re-grants the same port the next cycle; VALID pulses are separated by at least 2 cycles.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the unified memory arbiter
package mips_mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

  typedef enum logic {GNT_IF, GNT_MEM} grant_t;

  // All-ones lane mask wide enough for any supported data width; users truncate it.
  localparam logic [31:0] BYTE_SEL_ALL = '1;

endpackage

// File: rtl/unified_mem_arbiter_arb_pick.sv
// rtl/unified_mem_arbiter_arb_pick.sv - combinational winner selection between fetch and load/store
// ARB_RR_EN: ties go to the port not granted last; otherwise MEM has fixed priority.
module arb_pick
  import mips_mem_pkg::*;
(
  input  logic   i_if_req,
  input  logic   i_mem_req,
  input  logic   i_excl_if,
  input  logic   i_excl_mem,
`ifdef ARB_RR_EN
  input  grant_t i_last_gnt,
`endif
  output logic   o_valid,
  output grant_t o_gnt
);

  logic w_if;
  logic w_mem;

  assign w_if  = i_if_req & ~i_excl_if;
  assign w_mem = i_mem_req & ~i_excl_mem;

  always_comb begin
    o_valid = w_if | w_mem;
    o_gnt   = GNT_IF;
    if (w_if && w_mem) begin
`ifdef ARB_RR_EN
      if (i_last_gnt == GNT_IF) begin
        o_gnt = GNT_MEM;
      end else begin
        o_gnt = GNT_IF;
      end
`else
      o_gnt = GNT_MEM;
`endif
    end else if (w_mem) begin
      o_gnt = GNT_MEM;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port sync RAM between instruction fetch and load/store
// ARB_RR_EN: round-robin tie-break in IDLE instead of fixed MEM priority.
module unified_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_valid,
  input  logic                i_mem_req,
  input  logic                i_mem_wen,
  input  logic [ADDR_W-1:0]   i_mem_addr,
  input  logic [DATA_W/8-1:0] i_mem_byte_sel,
  input  logic [DATA_W-1:0]   i_mem_sdata,
  output logic [DATA_W-1:0]   o_mem_ldata,
  output logic                o_mem_valid,
  output logic                o_stall,
  output logic                o_ram_cen,
  output logic                o_ram_wen,
  output logic [ADDR_W-1:0]   o_ram_addr,
  output logic [DATA_W/8-1:0] o_ram_byte_sel,
  output logic [DATA_W-1:0]   o_ram_sdata,
  input  logic [DATA_W-1:0]   i_ram_ldata
);

  localparam int BSEL_W = DATA_W / 8;

  arb_state_t          r_state;
  grant_t              r_gnt;
  logic                r_ram_cen;
  logic                r_ram_wen;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [BSEL_W-1:0]   r_ram_bsel;
  logic [DATA_W-1:0]   r_ram_sdata;
  logic                r_if_valid;
  logic                r_mem_valid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_ldata;

  logic                w_excl_if;
  logic                w_excl_mem;
  logic                w_pick_valid;
  grant_t              w_pick_gnt;
  logic                w_cmd_wen;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic [BSEL_W-1:0]   w_cmd_bsel;

  // The port completing in RESP still holds REQ for the finished access.
  assign w_excl_if  = (r_state == RESP) && (r_gnt == GNT_IF);
  assign w_excl_mem = (r_state == RESP) && (r_gnt == GNT_MEM);

  arb_pick u_arb_pick (
    .i_if_req   (i_if_req),
    .i_mem_req  (i_mem_req),
    .i_excl_if  (w_excl_if),
    .i_excl_mem (w_excl_mem),
`ifdef ARB_RR_EN
    .i_last_gnt (r_gnt),
`endif
    .o_valid    (w_pick_valid),
    .o_gnt      (w_pick_gnt)
  );

  assign w_cmd_wen  = (w_pick_gnt == GNT_MEM) && i_mem_wen;
  assign w_cmd_addr = (w_pick_gnt == GNT_MEM) ? i_mem_addr : i_if_addr;
  assign w_cmd_bsel = (w_pick_gnt == GNT_MEM) ? i_mem_byte_sel : BSEL_W'(BYTE_SEL_ALL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= GNT_IF;
      r_ram_cen   <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_bsel  <= '0;
      r_ram_sdata <= '0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_ldata <= '0;
    end else begin
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_state     <= ACCESS;
            r_gnt       <= w_pick_gnt;
            r_ram_cen   <= 1'b1;
            r_ram_wen   <= w_cmd_wen;
            r_ram_addr  <= w_cmd_addr;
            r_ram_bsel  <= w_cmd_bsel;
            r_ram_sdata <= i_mem_sdata;
          end
        end
        ACCESS: begin
          r_state     <= RESP;
          r_ram_cen   <= 1'b0;
          r_ram_wen   <= 1'b0;
          r_if_valid  <= (r_gnt == GNT_IF);
          r_mem_valid <= (r_gnt == GNT_MEM);
        end
        RESP: begin
          if (r_gnt == GNT_IF) begin
            r_if_rdata <= i_ram_ldata;
          end else begin
            r_mem_ldata <= i_ram_ldata;
          end
          if (w_pick_valid) begin
            r_state     <= ACCESS;
            r_gnt       <= w_pick_gnt;
            r_ram_cen   <= 1'b1;
            r_ram_wen   <= w_cmd_wen;
            r_ram_addr  <= w_cmd_addr;
            r_ram_bsel  <= w_cmd_bsel;
            r_ram_sdata <= i_mem_sdata;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data is on the RAM bus during the VALID cycle; the register holds it afterwards.
  assign o_if_rdata     = r_if_valid  ? i_ram_ldata : r_if_rdata;
  assign o_mem_ldata    = r_mem_valid ? i_ram_ldata : r_mem_ldata;
  assign o_if_valid     = r_if_valid;
  assign o_mem_valid    = r_mem_valid;
  assign o_stall        = (i_if_req & ~r_if_valid) | (i_mem_req & ~r_mem_valid);
  assign o_ram_cen      = r_ram_cen;
  assign o_ram_wen      = r_ram_wen;
  assign o_ram_addr     = r_ram_addr;
  assign o_ram_byte_sel = r_ram_bsel;
  assign o_ram_sdata    = r_ram_sdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  bsel;
    logic [31:0] sdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_bsel = '0;
  logic [31:0] mem_sdata = '0;
  logic [31:0] mem_ldata;
  logic        mem_valid;
  logic        stall;
  logic        ram_cen;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [3:0]  ram_bsel;
  logic [31:0] ram_sdata;
  logic [31:0] ram_ldata = '0;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] ram [64];
  logic [31:0] shadow [64];

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_if_req       (if_req),
    .i_if_addr      (if_addr),
    .o_if_rdata     (if_rdata),
    .o_if_valid     (if_valid),
    .i_mem_req      (mem_req),
    .i_mem_wen      (mem_wen),
    .i_mem_addr     (mem_addr),
    .i_mem_byte_sel (mem_bsel),
    .i_mem_sdata    (mem_sdata),
    .o_mem_ldata    (mem_ldata),
    .o_mem_valid    (mem_valid),
    .o_stall        (stall),
    .o_ram_cen      (ram_cen),
    .o_ram_wen      (ram_wen),
    .o_ram_addr     (ram_addr),
    .o_ram_byte_sel (ram_bsel),
    .o_ram_sdata    (ram_sdata),
    .i_ram_ldata    (ram_ldata)
  );

  // Single-port synchronous RAM, read-before-write, 64 words.
  always @(posedge clk) begin
    if (ram_cen) begin
      ram_ldata <= ram[ram_addr[7:2]];
      if (ram_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_bsel[b]) ram[ram_addr[7:2]][8*b +: 8] = ram_sdata[8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    if_req  = 1'b0;
    mem_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_t        pcmd [2];
    cmd_t        icmd;
    bit          pend [2];
    bit          busy [2];
    bit          seen_v [2];
    bit          exp_v [2];
    bit          inflight;
    int          comp_cyc;
    int          port;
    int          last;
    int          prob;
    int          w;
    logic [31:0] exp_d;
    logic [31:0] r;

    for (int i = 0; i < 64; i++) ram[i] = $urandom();

    // Reset state
    do_reset();
    check("rst_if_valid", if_valid, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_ldata", mem_ldata, 0);
    check("rst_stall", stall, 0);
    check("rst_cen", ram_cen, 0);
    check("rst_wen", ram_wen, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_bsel", ram_bsel, 0);
    check("rst_sdata", ram_sdata, 0);

    ram[4]  = 32'h2408_0005;
    ram[16] = 32'h1122_3344;

    // Lone fetch
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    #1 check("fetch_stall_t", stall, 1);
    tick();
    check("fetch_cen_t1", ram_cen, 1);
    check("fetch_addr_t1", ram_addr, 32'h10);
    check("fetch_bsel_t1", ram_bsel, 4'hF);
    check("fetch_wen_t1", ram_wen, 0);
    check("fetch_valid_t1", if_valid, 0);
    check("fetch_stall_t1", stall, 1);
    tick();
    check("fetch_valid_t2", if_valid, 1);
    check("fetch_rdata_t2", if_rdata, 32'h2408_0005);
    check("fetch_stall_t2", stall, 0);
    check("fetch_cen_t2", ram_cen, 0);
    if_req = 1'b0;
    tick();
    check("fetch_valid_t3", if_valid, 0);
    check("fetch_rdata_hold", if_rdata, 32'h2408_0005);

    // Store then load
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h40; mem_bsel = 4'b0011; mem_sdata = 32'hAABB_CCDD;
    #1 check("store_stall_t", stall, 1);
    tick();
    check("store_cen_t1", ram_cen, 1);
    check("store_wen_t1", ram_wen, 1);
    check("store_addr_t1", ram_addr, 32'h40);
    check("store_bsel_t1", ram_bsel, 4'b0011);
    check("store_sdata_t1", ram_sdata, 32'hAABB_CCDD);
    tick();
    check("store_valid_t2", mem_valid, 1);
    check("store_cen_t2", ram_cen, 0);
    mem_req = 1'b0;
    tick();
    mem_req = 1'b1; mem_wen = 1'b0; mem_bsel = 4'hF;
    tick();
    check("load_cen_t1", ram_cen, 1);
    check("load_wen_t1", ram_wen, 0);
    tick();
    check("load_valid_t2", mem_valid, 1);
    check("load_ldata_t2", mem_ldata, 32'h1122_CCDD);
    check("load_if_valid", if_valid, 0);
    mem_req = 1'b0;
    tick();

    // Simultaneous requests from IDLE after reset: MEM first in either build
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h40; mem_bsel = 4'hF;
    tick();
    check("both_cen_t1", ram_cen, 1);
    check("both_addr_t1", ram_addr, 32'h40);
    tick();
    check("both_mem_valid_t2", mem_valid, 1);
    check("both_if_valid_t2", if_valid, 0);
    check("both_cen_t2", ram_cen, 0);
    check("both_stall_t2", stall, 1);
    mem_req = 1'b0;
    tick();
    check("both_cen_t3", ram_cen, 1);
    check("both_addr_t3", ram_addr, 32'h10);
    check("both_mem_valid_t3", mem_valid, 0);
    tick();
    check("both_if_valid_t4", if_valid, 1);
    check("both_rdata_t4", if_rdata, 32'h2408_0005);
    check("both_cen_t4", ram_cen, 0);
    if_req = 1'b0;
    tick();

    // Reset during the ACCESS cycle of a store
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h80; mem_bsel = 4'hF; mem_sdata = 32'hDEAD_BEEF;
    tick();
    check("rst_store_cen_pre", ram_cen, 1);
    rst_n = 1'b0; mem_req = 1'b0;
    #1;
    check("rst_store_cen", ram_cen, 0);
    check("rst_store_wen", ram_wen, 0);
    check("rst_store_addr", ram_addr, 0);
    check("rst_store_ldata", mem_ldata, 0);
    check("rst_store_rdata", if_rdata, 0);
    check("rst_store_stall", stall, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_mem_valid", mem_valid, 0);
      check("post_rst_if_valid", if_valid, 0);
      check("post_rst_cen", ram_cen, 0);
    end

    // Randomized traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < 64; i++) shadow[i] = ram[i];
    pend = '{0, 0}; busy = '{0, 0}; seen_v = '{0, 0};
    inflight = 0; comp_cyc = 0; port = 0; last = 0;
    for (int c = 0; c < 600; c++) begin
      prob = (c < 150) ? 100 : (c < 400) ? 50 : 20;
      for (int p = 0; p < 2; p++) begin
        if (busy[p] && seen_v[p]) busy[p] = 0;
        if (!busy[p]) begin
          if ($urandom_range(0, 99) < prob) begin
            busy[p] = 1;
            pend[p] = 1;
            r = $urandom();
            if (p == 0) begin
              pcmd[0] = '{addr: r, wen: 1'b0, bsel: 4'hF, sdata: 32'h0};
              if_req = 1'b1; if_addr = r;
            end else begin
              pcmd[1] = '{addr: r, wen: 1'($urandom_range(0, 1)),
                          bsel: 4'($urandom_range(0, 15)), sdata: $urandom()};
              mem_req = 1'b1; mem_wen = pcmd[1].wen; mem_addr = r;
              mem_bsel = pcmd[1].bsel; mem_sdata = pcmd[1].sdata;
            end
          end else begin
            if (p == 0) if_req = 1'b0;
            else mem_req = 1'b0;
          end
        end
      end
      #1;
      exp_v = '{0, 0};
      if (inflight && comp_cyc == c + 1) begin
        check("rnd_cen_access", ram_cen, 1);
        check("rnd_addr", ram_addr, icmd.addr);
        check("rnd_wen", ram_wen, icmd.wen);
        check("rnd_bsel", ram_bsel, icmd.bsel);
        if (icmd.wen) check("rnd_sdata", ram_sdata, icmd.sdata);
      end else begin
        check("rnd_cen_idle", ram_cen, 0);
      end
      if (inflight && comp_cyc == c) begin
        exp_v[port] = 1;
        exp_d = shadow[icmd.addr[7:2]];
        if (port == 0) check("rnd_if_rdata", if_rdata, exp_d);
        else if (!icmd.wen) check("rnd_mem_ldata", mem_ldata, exp_d);
        if (icmd.wen) begin
          for (int b = 0; b < 4; b++)
            if (icmd.bsel[b]) shadow[icmd.addr[7:2]][8*b +: 8] = icmd.sdata[8*b +: 8];
        end
        inflight = 0;
      end
      check("rnd_if_valid", if_valid, exp_v[0]);
      check("rnd_mem_valid", mem_valid, exp_v[1]);
      check("rnd_stall", stall, (if_req & ~exp_v[0]) | (mem_req & ~exp_v[1]));
      if (!inflight && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) begin
`ifdef ARB_RR_EN
          w = (last == 0) ? 1 : 0;
`else
          w = 1;
`endif
        end else begin
          w = pend[1] ? 1 : 0;
        end
        pend[w]  = 0;
        inflight = 1;
        comp_cyc = c + 2;
        port     = w;
        icmd     = pcmd[w];
        last     = w;
      end
      seen_v[0] = if_valid;
      seen_v[1] = mem_valid;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
